rv_multicycle_core: RTL and testbench

Parametrised multi-cycle RISC-V integer core, the successor to the single-cycle RV64 top level. It fetches from the instruction memory and accesses the data memory through ready-qualified request ports, so it can sit behind caches or slow memories. It executes a fixed integer subset at a data width chosen by XLEN (32 or 64). It halts cleanly on any unsupported encoding.

---
 rtl/rv_multicycle_core.sv | 194 +++++++++++++++++++
 tb/tb_rv_multicycle_core.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_multicycle_core.sv
// Multi-cycle RISC-V integer core: FETCH/EXEC/MEM/HALT sequencer with ready-qualified
// instruction and data ports, running a small integer subset at XLEN 32 or 64.
module rv_multicycle_core #(
  parameter int          XLEN     = 64,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_ren_I,
  output logic [29:0]     mem_addr_I,
  input  logic            mem_ready_I,
  input  logic [31:0]     mem_rdata_I,
  output logic            mem_ren_D,
  output logic            mem_wen_D,
  output logic [31:0]     mem_addr_D,
  output logic [XLEN-1:0] mem_wdata_D,
  input  logic            mem_ready_D,
  input  logic [XLEN-1:0] mem_rdata_D,
  output logic            halted,
  output logic [31:0]     instret
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  // Only the native-width load/store is supported: ld/sd on RV64, lw/sw on RV32.
  localparam logic [2:0] F3_MEM    = (XLEN == 64) ? 3'b011 : 3'b010;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  state_t                     state;
  logic [31:0]                pc;
  logic [31:0]                ir;
  logic [31:0][XLEN-1:0]      regs;
  logic                       is_load_q;

  logic [6:0]                 opcode;
  logic [4:0]                 rd;
  logic [2:0]                 funct3;
  logic [4:0]                 rs1;
  logic [4:0]                 rs2;
  logic [6:0]                 funct7;
  logic signed [XLEN-1:0]     rs1_val;
  logic signed [XLEN-1:0]     rs2_val;
  logic signed [XLEN-1:0]     imm_i;
  logic signed [XLEN-1:0]     imm_s;
  logic signed [XLEN-1:0]     imm_b;
  logic signed [XLEN-1:0]     imm_j;
  logic [31:0]                pc_plus4;

  logic                       legal;
  logic                       wr_en;
  logic [XLEN-1:0]            wr_val;
  logic [31:0]                next_pc;
  logic                       is_load;
  logic                       is_store;
  logic [31:0]                eff_addr;

  assign opcode  = ir[6:0];
  assign rd      = ir[11:7];
  assign funct3  = ir[14:12];
  assign rs1     = ir[19:15];
  assign rs2     = ir[24:20];
  assign funct7  = ir[31:25];

  assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];

  assign imm_i   = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign imm_s   = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b   = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j   = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  assign pc_plus4   = pc + 32'd4;
  assign mem_addr_I = pc[31:2];

  always_comb begin
    legal    = 1'b0;
    wr_en    = 1'b0;
    wr_val   = '0;
    next_pc  = pc_plus4;
    is_load  = 1'b0;
    is_store = 1'b0;
    eff_addr = rs1_val[31:0] + imm_i[31:0];
    case (opcode)
      OP_R: begin
        wr_en = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000: begin legal = 1'b1; wr_val = rs1_val + rs2_val; end
            3'b010: begin legal = 1'b1; wr_val[0] = (rs1_val < rs2_val); end
            3'b110: begin legal = 1'b1; wr_val = rs1_val | rs2_val; end
            3'b111: begin legal = 1'b1; wr_val = rs1_val & rs2_val; end
            default: legal = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          legal  = 1'b1;
          wr_val = rs1_val - rs2_val;
        end
      end
      OP_IMM: begin
        legal  = (funct3 == 3'b000);
        wr_en  = 1'b1;
        wr_val = rs1_val + imm_i;
      end
      OP_LOAD: begin
        legal   = (funct3 == F3_MEM);
        is_load = 1'b1;
      end
      OP_STORE: begin
        legal    = (funct3 == F3_MEM);
        is_store = 1'b1;
        eff_addr = rs1_val[31:0] + imm_s[31:0];
      end
      OP_BRANCH: begin
        legal = (funct3 == 3'b000);
        if (rs1_val == rs2_val) next_pc = pc + imm_b[31:0];
      end
      OP_JAL: begin
        legal   = 1'b1;
        wr_en   = 1'b1;
        wr_val  = XLEN'(pc_plus4);
        next_pc = pc + imm_j[31:0];
      end
      default: legal = 1'b0;
    endcase
  end

  // Request strobes and halted are registered here so no ready/rdata input reaches an output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      ir          <= '0;
      regs        <= '0;
      is_load_q   <= 1'b0;
      instret     <= '0;
      halted      <= 1'b0;
      mem_ren_I   <= 1'b1;
      mem_ren_D   <= 1'b0;
      mem_wen_D   <= 1'b0;
      mem_addr_D  <= '0;
      mem_wdata_D <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready_I) begin
            ir        <= mem_rdata_I;
            mem_ren_I <= 1'b0;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (!legal) begin
            halted <= 1'b1;
            state  <= HALT;
          end else if (is_load || is_store) begin
            mem_addr_D  <= eff_addr;
            mem_wdata_D <= rs2_val;
            is_load_q   <= is_load;
            mem_ren_D   <= is_load;
            mem_wen_D   <= is_store;
            state       <= MEM;
          end else begin
            if (wr_en && rd != 5'd0) regs[rd] <= wr_val;
            pc        <= next_pc;
            instret   <= instret + 32'd1;
            mem_ren_I <= 1'b1;
            state     <= FETCH;
          end
        end
        MEM: begin
          if (mem_ready_D) begin
            if (is_load_q && rd != 5'd0) regs[rd] <= mem_rdata_D;
            pc        <= pc_plus4;
            instret   <= instret + 32'd1;
            mem_ren_D <= 1'b0;
            mem_wen_D <= 1'b0;
            mem_ren_I <= 1'b1;
            state     <= FETCH;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_multicycle_core.sv
// Directed bench for rv_multicycle_core (XLEN=64): programs run from a small instruction
// ROM against a data memory model with configurable wait states.
module tb_rv_multicycle_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_ren_I;
  logic [29:0] mem_addr_I;
  logic        mem_ready_I;
  logic [31:0] mem_rdata_I;
  logic        mem_ren_D;
  logic        mem_wen_D;
  logic [31:0] mem_addr_D;
  logic [63:0] mem_wdata_D;
  logic        mem_ready_D;
  logic [63:0] mem_rdata_D;
  logic        halted;
  logic [31:0] instret;

  logic [31:0] imem [64];
  logic [63:0] dmem [64];
  logic [63:0] dpre [64];
  logic [31:0] ftrace [16];
  int          f_n = 0;
  int          icnt = 0;
  int          dcnt = 0;
  int          iws = 0;
  int          dws = 0;
  int          both_cnt = 0;
  int          n_chk = 0;
  int          n_err = 0;

  rv_multicycle_core #(.XLEN(64), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_ren_I(mem_ren_I), .mem_addr_I(mem_addr_I),
    .mem_ready_I(mem_ready_I), .mem_rdata_I(mem_rdata_I),
    .mem_ren_D(mem_ren_D), .mem_wen_D(mem_wen_D),
    .mem_addr_D(mem_addr_D), .mem_wdata_D(mem_wdata_D),
    .mem_ready_D(mem_ready_D), .mem_rdata_D(mem_rdata_D),
    .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  assign mem_ready_I = mem_ren_I && (icnt >= iws);
  assign mem_rdata_I = imem[mem_addr_I[5:0]];
  assign mem_ready_D = (mem_ren_D || mem_wen_D) && (dcnt >= dws);
  assign mem_rdata_D = dmem[mem_addr_D[8:3]];

  always @(posedge clk) begin
    if (mem_ren_D && mem_wen_D) both_cnt <= both_cnt + 1;
    if (!rst_n) begin
      dmem <= dpre;
      f_n  <= 0;
      icnt <= 0;
      dcnt <= 0;
    end else begin
      if (mem_ren_I && !mem_ready_I) icnt <= icnt + 1; else icnt <= 0;
      if ((mem_ren_D || mem_wen_D) && !mem_ready_D) dcnt <= dcnt + 1; else dcnt <= 0;
      if (mem_wen_D && mem_ready_D) dmem[mem_addr_D[8:3]] <= mem_wdata_D;
      if (mem_ren_I && mem_ready_I) begin
        if (f_n < 16) ftrace[f_n] <= {mem_addr_I, 2'b00};
        f_n <= f_n + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    logic [11:0] im;
    im = 12'(imm);
    return {im, 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    logic [11:0] im;
    im = 12'(imm);
    return {im[11:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1);
    logic [12:0] im;
    im = 13'(imm);
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'b000, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [20:0] im;
    im = 21'(imm);
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'b1101111};
  endfunction

  task automatic clear_mems();
    for (int k = 0; k < 64; k++) begin
      imem[k] = 32'hFFFF_FFFF;
      dpre[k] = 64'hA5A5_A5A5_A5A5_A5A5;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic next(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int k;
    k = 0;
    while (!halted && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, halted, 1'b1);
  endtask

  logic [31:0] exp_trace [9];
  int          req;

  initial begin
    // Reset state
    clear_mems();
    imem[0] = enc_i(5, 0, 0, 1, 7'b0010011);
    do_reset();
    chk("rst_ren_I", mem_ren_I, 1'b1);
    chk("rst_addr_I", mem_addr_I, 30'h0);
    chk("rst_ren_D", mem_ren_D, 1'b0);
    chk("rst_wen_D", mem_wen_D, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_addr_D", mem_addr_D, 32'd0);
    chk("rst_wdata_D", mem_wdata_D, 64'd0);

    // ALU sequence, zero wait states; results exposed through stores
    clear_mems();
    iws = 0; dws = 0;
    imem[0]  = enc_i(5, 0, 0, 1, 7'b0010011);
    imem[1]  = enc_i(-3, 0, 0, 2, 7'b0010011);
    imem[2]  = enc_r(0, 2, 1, 0, 3);
    imem[3]  = enc_r(32, 1, 2, 0, 4);
    imem[4]  = enc_r(0, 1, 2, 2, 5);
    imem[5]  = enc_r(0, 2, 1, 2, 6);
    imem[6]  = enc_r(0, 2, 1, 7, 7);
    imem[7]  = enc_r(0, 2, 1, 6, 8);
    imem[8]  = enc_s(0, 3, 0, 3);
    imem[9]  = enc_s(8, 4, 0, 3);
    imem[10] = enc_s(16, 5, 0, 3);
    imem[11] = enc_s(24, 6, 0, 3);
    imem[12] = enc_s(32, 7, 0, 3);
    imem[13] = enc_s(40, 8, 0, 3);
    imem[14] = 32'hFFFF_FFFF;
    do_reset();
    next(10);
    chk("alu_instret10", instret, 32'd5);
    wait_halt("alu_halt", 200);
    chk("alu_add", dmem[0], 64'd2);
    chk("alu_sub", dmem[1], 64'hFFFF_FFFF_FFFF_FFF8);
    chk("alu_slt_t", dmem[2], 64'd1);
    chk("alu_slt_f", dmem[3], 64'd0);
    chk("alu_and", dmem[4], 64'd5);
    chk("alu_or", dmem[5], 64'hFFFF_FFFF_FFFF_FFFD);
    chk("alu_instret", instret, 32'd14);

    // Store/load with 2 data wait states
    clear_mems();
    iws = 0; dws = 2;
    dpre[2] = 64'hDEAD_BEEF_0123_4567;
    imem[0] = enc_i(16, 0, 3, 1, 7'b0000011);
    imem[1] = enc_s(8, 1, 0, 3);
    imem[2] = enc_i(8, 0, 3, 6, 7'b0000011);
    imem[3] = enc_s(24, 6, 0, 3);
    imem[4] = enc_r(1, 2, 1, 0, 3);
    do_reset();
    next(2);
    chk("ld_ren_D", mem_ren_D, 1'b1);
    chk("ld_addr_D", mem_addr_D, 32'd16);
    next(3);
    chk("ld_instret", instret, 32'd1);
    next(1);
    chk("sd_exec_wen", mem_wen_D, 1'b0);
    for (int c = 0; c < 3; c++) begin
      next(1);
      chk("sd_wen", mem_wen_D, 1'b1);
      chk("sd_ren", mem_ren_D, 1'b0);
      chk("sd_addr", mem_addr_D, 32'd8);
      chk("sd_wdata", mem_wdata_D, 64'hDEAD_BEEF_0123_4567);
    end
    next(1);
    chk("sd_done_wen", mem_wen_D, 1'b0);
    chk("sd_instret", instret, 32'd2);
    next(5);
    chk("ld2_instret", instret, 32'd3);
    wait_halt("ls_halt", 200);
    chk("ls_mem8", dmem[1], 64'hDEAD_BEEF_0123_4567);
    chk("ls_x6", dmem[3], 64'hDEAD_BEEF_0123_4567);
    chk("ls_instret", instret, 32'd4);

    // Control flow with 1 fetch wait state
    clear_mems();
    iws = 1; dws = 0;
    imem[0]  = enc_i(1, 0, 0, 1, 7'b0010011);
    imem[1]  = enc_b(8, 0, 1);
    imem[2]  = enc_b(8, 0, 0);
    imem[3]  = enc_j(16, 0);
    imem[4]  = enc_j(-4, 7);
    imem[7]  = enc_i(9, 0, 0, 0, 7'b0010011);
    imem[8]  = enc_s(0, 0, 0, 3);
    imem[9]  = enc_s(8, 7, 0, 3);
    imem[10] = enc_i(0, 0, 2, 1, 7'b0000011);
    exp_trace = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h0C, 32'h1C, 32'h20, 32'h24, 32'h28};
    do_reset();
    wait_halt("cf_halt", 300);
    chk("cf_nfetch", f_n, 9);
    for (int k = 0; k < 9; k++) chk($sformatf("cf_fetch%0d", k), ftrace[k], exp_trace[k]);
    chk("cf_x0", dmem[0], 64'd0);
    chk("cf_x7", dmem[1], 64'h14);
    chk("cf_instret", instret, 32'd8);

    // Illegal instruction: halt timing, quiet bus, restart
    clear_mems();
    iws = 0; dws = 0;
    imem[0] = enc_i(5, 0, 0, 1, 7'b0010011);
    imem[1] = 32'hFFFF_FFFF;
    do_reset();
    next(3);
    chk("ill_exec_halted", halted, 1'b0);
    next(1);
    chk("ill_halted", halted, 1'b1);
    chk("ill_instret", instret, 32'd1);
    req = 0;
    for (int c = 0; c < 20; c++) begin
      if (mem_ren_I || mem_ren_D || mem_wen_D) req++;
      next(1);
    end
    chk("ill_quiet", req, 0);
    do_reset();
    chk("ill_rst_halted", halted, 1'b0);
    chk("ill_rst_ren_I", mem_ren_I, 1'b1);
    chk("ill_rst_addr_I", mem_addr_I, 30'h0);
    chk("ill_rst_instret", instret, 32'd0);

    // Reset asserted while a load waits in MEM
    clear_mems();
    iws = 0; dws = 1000;
    dpre[0] = 64'h1234_5678_9ABC_DEF0;
    imem[0] = enc_i(0, 0, 3, 5, 7'b0000011);
    do_reset();
    next(3);
    chk("mr_ren_D", mem_ren_D, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_drop_ren_D", mem_ren_D, 1'b0);
    chk("mr_ren_I", mem_ren_I, 1'b1);
    chk("mr_addr_I", mem_addr_I, 30'h0);
    chk("mr_instret", instret, 32'd0);
    clear_mems();
    dws = 0;
    imem[0] = enc_s(8, 5, 0, 3);
    do_reset();
    wait_halt("mr_halt", 100);
    chk("mr_x5", dmem[1], 64'd0);
    chk("mr_instret2", instret, 32'd1);

    chk("no_dual_req", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
